// File: rtl/morse_pkg.sv
// Shared Morse keyer types, timing units and state encoding.
// The MORSE_WORD_GAP_EN build adds the word-gap state.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    GAP      = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } state_t;

  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int ELEM_GAP_UNITS = 1;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 7;

  localparam logic [5:0] SPACE_CODE = 6'd36;

  // code[width-1] is sent first; 1 = dash, 0 = dot
  typedef struct packed {
    logic [4:0] code;
    logic [2:0] width;
  } morse_t;

  function automatic morse_t mk(
    input logic [4:0] c,
    input logic [2:0] w
  );
    morse_t m;
    m.code  = c;
    m.width = w;
    return m;
  endfunction

endpackage

// File: rtl/to_morse.sv
// Combinational character-code to Morse element lookup.
// Codes outside 0-35 fall back to the pattern for '0'.
module to_morse
  import morse_pkg::*;
(
  input  logic [5:0] ch,
  output morse_t     m
);

  always_comb begin
    m = mk(5'b11111, 3'd5);
    unique case (ch)
      6'd0:  m = mk(5'b11111, 3'd5);
      6'd1:  m = mk(5'b01111, 3'd5);
      6'd2:  m = mk(5'b00111, 3'd5);
      6'd3:  m = mk(5'b00011, 3'd5);
      6'd4:  m = mk(5'b00001, 3'd5);
      6'd5:  m = mk(5'b00000, 3'd5);
      6'd6:  m = mk(5'b10000, 3'd5);
      6'd7:  m = mk(5'b11000, 3'd5);
      6'd8:  m = mk(5'b11100, 3'd5);
      6'd9:  m = mk(5'b11110, 3'd5);
      6'd10: m = mk(5'b00001, 3'd2);
      6'd11: m = mk(5'b01000, 3'd4);
      6'd12: m = mk(5'b01010, 3'd4);
      6'd13: m = mk(5'b00100, 3'd3);
      6'd14: m = mk(5'b00000, 3'd1);
      6'd15: m = mk(5'b00010, 3'd4);
      6'd16: m = mk(5'b00110, 3'd3);
      6'd17: m = mk(5'b00000, 3'd4);
      6'd18: m = mk(5'b00000, 3'd2);
      6'd19: m = mk(5'b00111, 3'd4);
      6'd20: m = mk(5'b00101, 3'd3);
      6'd21: m = mk(5'b00100, 3'd4);
      6'd22: m = mk(5'b00011, 3'd2);
      6'd23: m = mk(5'b00010, 3'd2);
      6'd24: m = mk(5'b00111, 3'd3);
      6'd25: m = mk(5'b00110, 3'd4);
      6'd26: m = mk(5'b01101, 3'd4);
      6'd27: m = mk(5'b00010, 3'd3);
      6'd28: m = mk(5'b00000, 3'd3);
      6'd29: m = mk(5'b00001, 3'd1);
      6'd30: m = mk(5'b00001, 3'd3);
      6'd31: m = mk(5'b00001, 3'd4);
      6'd32: m = mk(5'b00011, 3'd3);
      6'd33: m = mk(5'b01001, 3'd4);
      6'd34: m = mk(5'b01011, 3'd4);
      6'd35: m = mk(5'b01100, 3'd4);
      default: m = mk(5'b11111, 3'd5);
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: one character per handshake, timed key line.
// Define MORSE_WORD_GAP_EN to send code 36 as a 7-unit word gap.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 50_000_000 / 10,
  parameter int CNT_W       = $clog2(UNIT_CYCLES * 7 + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] ld(input int units);
    return CNT_W'(units * UNIT_CYCLES - 1);
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [4:0]       code, code_n;
  logic [2:0]       width, width_n;

  morse_t     lk;
  logic       accept;
  logic       cnt_last;
  logic       more;
  logic [2:0] idx_first;
  logic [2:0] idx_dec;

  to_morse u_lut (
    .ch (in_data),
    .m  (lk)
  );

  assign accept    = in_valid && (state == IDLE);
  assign cnt_last  = (cnt == '0);
  assign idx_first = (lk.width == 3'd0) ? 3'd0 : lk.width - 3'd1;
  assign idx_dec   = idx - 3'd1;
  // width 0 or 1 is a single element regardless of idx
  assign more      = (idx != 3'd0) && (width > 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      code  <= '0;
      width <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      code  <= code_n;
      width <= width_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    code_n  = code;
    width_n = width;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef MORSE_WORD_GAP_EN
          if (in_data == SPACE_CODE) begin
            state_n = WORD_GAP;
            cnt_n   = ld(WORD_GAP_UNITS);
          end else
`endif
          begin
            code_n  = lk.code;
            width_n = lk.width;
            idx_n   = idx_first;
            state_n = MARK;
            cnt_n   = ld(lk.code[idx_first] ? DASH_UNITS : DOT_UNITS);
          end
        end
      end
      MARK: begin
        if (!cnt_last) begin
          cnt_n = cnt - ONE;
        end else if (more) begin
          state_n = GAP;
          cnt_n   = ld(ELEM_GAP_UNITS);
        end else begin
          state_n = CHAR_GAP;
          cnt_n   = ld(CHAR_GAP_UNITS);
        end
      end
      GAP: begin
        if (!cnt_last) begin
          cnt_n = cnt - ONE;
        end else begin
          idx_n   = idx_dec;
          state_n = MARK;
          cnt_n   = ld(code[idx_dec] ? DASH_UNITS : DOT_UNITS);
        end
      end
      CHAR_GAP: begin
        if (!cnt_last) cnt_n = cnt - ONE;
        else           state_n = IDLE;
      end
`ifdef MORSE_WORD_GAP_EN
      WORD_GAP: begin
        if (!cnt_last) cnt_n = cnt - ONE;
        else           state_n = IDLE;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign key      = (state == MARK);
  assign done     = cnt_last &&
                    ((state == CHAR_GAP) || (state == WORD_GAP));

endmodule

// File: tb/tb_morse_keyer.sv
// Randomized bench for morse_keyer with a dot/dash string model.
// Honours MORSE_WORD_GAP_EN the same way as the design.
module tb_morse_keyer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] in_data = 6'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, key, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_at = 0;

  // expected per-cycle outputs after an accept: {key, done}
  logic [1:0] q[$];

  string tbl[36] = '{
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----.",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
    "....", "..", ".---", "-.-", ".-..", "--", "-.",
    "---", ".--.", "--.-", ".-.", "...", "-", "..-",
    "...-", ".--", "-..-", "-.--", "--.."
  };

  always #5 clk = ~clk;

  morse_keyer #(.UNIT_CYCLES(U)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key      (key),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic build(input int c);
    string s;
    int    n;
`ifdef MORSE_WORD_GAP_EN
    if (c == 36) begin
      repeat (7 * U - 1) q.push_back(2'b00);
      q.push_back(2'b01);
      return;
    end
`endif
    s = (c < 36) ? tbl[c] : "-----";
    for (int i = 0; i < s.len(); i++) begin
      n = (s[i] == "-") ? 3 * U : U;
      repeat (n) q.push_back(2'b10);
      if (i != s.len() - 1) repeat (U) q.push_back(2'b00);
    end
    repeat (3 * U - 1) q.push_back(2'b00);
    q.push_back(2'b01);
  endtask

  // reference model: idle when nothing queued, accepts on valid
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
    end else begin
      cyc++;
      if (q.size() != 0) begin
        void'(q.pop_front());
      end else if (in_valid) begin
        build(int'(in_data));
        acc_cnt++;
        acc_at = cyc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("key", {31'd0, key},
        {31'd0, (q.size() != 0) ? q[0][1] : 1'b0});
    chk("done", {31'd0, done},
        {31'd0, (q.size() != 0) ? q[0][0] : 1'b0});
    chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
  end

  task automatic send(input logic [5:0] c, output int at);
    int start;
    start    = acc_cnt;
    at       = -1;
    in_data  = c;
    in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) begin
        at = acc_at;
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 6'($urandom);
    if (at < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: code %0d never accepted", c);
    end
  endtask

  task automatic watch(
    output int nb, output int nk, output int nd, output int k1
  );
    nb = 0; nk = 0; nd = 0; k1 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) k1 = int'(key);
      if (busy !== 1'b1) break;
      nb++;
      if (key)  nk++;
      if (done) nd++;
    end
  endtask

  task automatic measure(
    input logic [5:0] c,
    output int nb, output int nk, output int nd, output int k1
  );
    int t;
    send(c, t);
    watch(nb, nk, nd, k1);
  endtask

  initial begin
    int   a, b, nb, nk, nd, k1, gap;
    logic kv[18], dv[18], rv[18], bv[18];

    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_key",   {31'd0, key},      32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(6'd14, a);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      kv[i] = key; dv[i] = done; rv[i] = in_ready; bv[i] = busy;
    end
    chk("E_key_c1",   {31'd0, kv[1]},  32'd1);
    chk("E_key_c4",   {31'd0, kv[4]},  32'd1);
    chk("E_key_c5",   {31'd0, kv[5]},  32'd0);
    chk("E_done_c15", {31'd0, dv[15]}, 32'd0);
    chk("E_done_c16", {31'd0, dv[16]}, 32'd1);
    chk("E_busy_c16", {31'd0, bv[16]}, 32'd1);
    chk("E_rdy_c16",  {31'd0, rv[16]}, 32'd0);
    chk("E_rdy_c17",  {31'd0, rv[17]}, 32'd1);

    send(6'd14, a);
    send(6'd29, b);
    chk("T_hold_delay", b - a, 32'd17);
    watch(nb, nk, nd, k1);
    chk("T_k1",   k1, 32'd1);
    chk("T_busy", nb, 32'd24);
    chk("T_key",  nk, 32'd12);
    chk("T_done", nd, 32'd1);

    measure(6'd10, nb, nk, nd, k1);
    chk("A_busy", nb, 32'd32);
    chk("A_key",  nk, 32'd16);
    chk("A_done", nd, 32'd1);

    measure(6'd5, nb, nk, nd, k1);
    chk("5_busy", nb, 32'd48);
    chk("5_key",  nk, 32'd20);

    measure(6'd36, nb, nk, nd, k1);
`ifdef MORSE_WORD_GAP_EN
    chk("sp_busy", nb, 32'd28);
    chk("sp_key",  nk, 32'd0);
`else
    chk("sp_busy", nb, 32'd88);
    chk("sp_key",  nk, 32'd60);
`endif
    chk("sp_done", nd, 32'd1);

    send(6'd24, a);
    repeat (20) @(negedge clk);
    chk("O_dash2", {31'd0, key}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("O_rst_key",  {31'd0, key},      32'd0);
    chk("O_rst_rdy",  {31'd0, in_ready}, 32'd1);
    chk("O_rst_busy", {31'd0, busy},     32'd0);
    chk("O_rst_done", {31'd0, done},     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    measure(6'd14, nb, nk, nd, k1);
    chk("E2_busy", nb, 32'd16);
    chk("E2_key",  nk, 32'd4);
    chk("E2_k1",   k1, 32'd1);

    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1 in_data = 6'($urandom);
      end
      send(6'($urandom_range(0, 63)), a);
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
